// File: rtl/bsg_manycore_fsb_master.sv
// rtl/bsg_manycore_fsb_master.sv - host-side FSB ring master for a manycore client node
module bsg_manycore_fsb_master #(
  parameter int          ring_width_p     = 80,
  parameter logic [3:0]  dest_id_p        = 4'hA,
  parameter int          num_links_p      = 3,
  parameter int          packet_width_p   = 16,
  parameter int          remote_credits_p = 4,
  localparam int tag_width_lp  = (2*num_links_p <= 1) ? 1 : $clog2(2*num_links_p),
  localparam int link_width_lp = (num_links_p <= 1) ? 1 : $clog2(num_links_p),
  localparam int cred_width_lp = (remote_credits_p+1 <= 1) ? 1 : $clog2(remote_credits_p+1)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               v_i,
  input  logic [link_width_lp-1:0]           link_i,
  input  logic [packet_width_p-1:0]          packet_i,
  output logic                               ready_o,
  output logic                               v_o,
  output logic [link_width_lp-1:0]           link_o,
  output logic [packet_width_p-1:0]          packet_o,
  input  logic                               yumi_i,
  output logic                               ring_v_o,
  output logic [ring_width_p-1:0]            ring_data_o,
  input  logic                               ring_yumi_i,
  input  logic                               ring_v_i,
  input  logic [ring_width_p-1:0]            ring_data_i,
  output logic                               ring_ready_o,
  output logic [num_links_p*cred_width_lp-1:0] credits_o,
  output logic [7:0]                         drop_count_o
);

  localparam logic [cred_width_lp-1:0] max_cred_lp = cred_width_lp'(remote_credits_p);

  logic [cred_width_lp-1:0] cred_q [num_links_p];
  logic [cred_width_lp-1:0] cred_d [num_links_p];
  logic                     slot_v_q, slot_v_d;
  logic [ring_width_p-1:0]  slot_data_q, slot_data_d;
  logic [link_width_lp-1:0] fifo_link_q [2];
  logic [link_width_lp-1:0] fifo_link_d [2];
  logic [packet_width_p-1:0] fifo_pkt_q [2];
  logic [packet_width_p-1:0] fifo_pkt_d [2];
  logic                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [7:0]               drop_q, drop_d;

  logic [cred_width_lp-1:0] tx_cred, rx_cred;
  logic                     tx_link_ok, accept;
  logic [ring_width_p-1:0]  tx_frame;
  logic [3:0]               rx_destid;
  logic                     rx_cmd, rx_fire, rx_hdr_ok, enq, credit_ret, deq, drop;
  logic [tag_width_lp-1:0]  rx_tag;
  logic [link_width_lp-1:0] rx_link;
  logic                     unused_ring_bits;

  assign unused_ring_bits = ^ring_data_i;

  always_comb begin
    tx_cred    = '0;
    rx_cred    = '0;
    tx_link_ok = 1'b0;
    for (int l = 0; l < num_links_p; l++) begin
      if (link_i == link_width_lp'(l)) begin
        tx_cred    = cred_q[l];
        tx_link_ok = 1'b1;
      end
      if (rx_link == link_width_lp'(l)) rx_cred = cred_q[l];
    end
  end

  // A link index beyond num_links_p has no counter and simply never becomes ready.
  assign ready_o = (!slot_v_q | ring_yumi_i) & tx_link_ok & (tx_cred != '0);
  assign accept  = v_i & ready_o;

  always_comb begin
    tx_frame = '0;
    tx_frame[ring_width_p-1 -: 4]            = dest_id_p;
    tx_frame[ring_width_p-5]                 = 1'b0;
    tx_frame[ring_width_p-6 -: tag_width_lp] = tag_width_lp'({link_i, 1'b0});
    tx_frame[packet_width_p-1:0]             = packet_i;
  end

  assign rx_destid    = ring_data_i[ring_width_p-1 -: 4];
  assign rx_cmd       = ring_data_i[ring_width_p-5];
  assign rx_tag       = ring_data_i[ring_width_p-6 -: tag_width_lp];
  assign rx_link      = link_width_lp'(rx_tag >> 1);
  assign ring_ready_o = (cnt_q != 2'd2);
  assign rx_fire      = ring_v_i & ring_ready_o;
  assign rx_hdr_ok    = (rx_destid == dest_id_p) & !rx_cmd
                      & (32'(rx_tag) < 32'(2*num_links_p));
  assign enq          = rx_fire & rx_hdr_ok & rx_tag[0];
  // Credit returns beyond the link's capacity are treated as garbage frames.
  assign credit_ret   = rx_fire & rx_hdr_ok & !rx_tag[0] & (rx_cred != max_cred_lp);
  assign drop         = rx_fire & !(enq | credit_ret);
  assign deq          = yumi_i & v_o;

  always_comb begin
    slot_v_d    = slot_v_q;
    slot_data_d = slot_data_q;
    if (accept) begin
      slot_v_d    = 1'b1;
      slot_data_d = tx_frame;
    end else if (ring_yumi_i) begin
      slot_v_d    = 1'b0;
    end

    for (int l = 0; l < num_links_p; l++) begin
      cred_d[l] = cred_q[l];
      if ((credit_ret && rx_link == link_width_lp'(l)) && !(accept && link_i == link_width_lp'(l)))
        cred_d[l] = cred_q[l] + 1'b1;
      else if (!(credit_ret && rx_link == link_width_lp'(l)) && (accept && link_i == link_width_lp'(l)))
        cred_d[l] = cred_q[l] - 1'b1;
    end

    fifo_link_d = fifo_link_q;
    fifo_pkt_d  = fifo_pkt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    if (enq) begin
      fifo_link_d[wr_ptr_q] = rx_link;
      fifo_pkt_d[wr_ptr_q]  = ring_data_i[packet_width_p-1:0];
      wr_ptr_d              = !wr_ptr_q;
    end
    if (deq) rd_ptr_d = !rd_ptr_q;
    if (enq && !deq)      cnt_d = cnt_q + 2'd1;
    else if (!enq && deq) cnt_d = cnt_q - 2'd1;

    drop_d = drop_q;
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_v_q    <= 1'b0;
      slot_data_q <= '0;
      for (int l = 0; l < num_links_p; l++) cred_q[l] <= max_cred_lp;
      for (int e = 0; e < 2; e++) begin
        fifo_link_q[e] <= '0;
        fifo_pkt_q[e]  <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      drop_q      <= 8'd0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_data_q <= slot_data_d;
      cred_q      <= cred_d;
      fifo_link_q <= fifo_link_d;
      fifo_pkt_q  <= fifo_pkt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign ring_v_o     = slot_v_q;
  assign ring_data_o  = slot_data_q;
  assign v_o          = (cnt_q != 2'd0);
  assign link_o       = fifo_link_q[rd_ptr_q];
  assign packet_o     = fifo_pkt_q[rd_ptr_q];
  assign drop_count_o = drop_q;

  always_comb begin
    credits_o = '0;
    for (int l = 0; l < num_links_p; l++)
      credits_o[l*cred_width_lp +: cred_width_lp] = cred_q[l];
  end

endmodule

// File: tb/tb_bsg_manycore_fsb_master.sv
// tb/tb_bsg_manycore_fsb_master.sv - vector-table bench for bsg_manycore_fsb_master
module tb_bsg_manycore_fsb_master;

  localparam int RW = 80;
  localparam int PW = 16;
  localparam int NL = 3;
  localparam int LW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          v_i, ready_o, v_o, yumi_i;
  logic [LW-1:0] link_i, link_o;
  logic [PW-1:0] packet_i, packet_o;
  logic          ring_v_o, ring_yumi_i, ring_v_i, ring_ready_o;
  logic [RW-1:0] ring_data_o, ring_data_i;
  logic [NL*CW-1:0] credits_o;
  logic [7:0]    drop_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_manycore_fsb_master #(
    .ring_width_p(RW), .dest_id_p(4'hA), .num_links_p(NL),
    .packet_width_p(PW), .remote_credits_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .link_i(link_i), .packet_i(packet_i), .ready_o(ready_o),
    .v_o(v_o), .link_o(link_o), .packet_o(packet_o), .yumi_i(yumi_i),
    .ring_v_o(ring_v_o), .ring_data_o(ring_data_o), .ring_yumi_i(ring_yumi_i),
    .ring_v_i(ring_v_i), .ring_data_i(ring_data_i), .ring_ready_o(ring_ready_o),
    .credits_o(credits_o), .drop_count_o(drop_count_o)
  );

  typedef struct {
    logic          v;
    logic [LW-1:0] link;
    logic [PW-1:0] pkt;
    logic          ryumi;
    logic          rv;
    logic [RW-1:0] rdata;
    logic          yumi;
    logic          e_rdy;
    logic          e_rrdy;
    logic          e_ringv;
    logic [RW-1:0] e_rdata;
    logic          e_vo;
    logic [LW-1:0] e_link;
    logic [PW-1:0] e_pkt;
    logic [NL*CW-1:0] e_cred;
    logic [7:0]    e_drop;
  } vec_t;

  vec_t vq[$];

  function automatic logic [RW-1:0] fr(input logic [3:0] d, input logic c,
                                       input logic [2:0] t, input logic [PW-1:0] p);
    logic [RW-1:0] f;
    f = '0;
    f[79:76] = d;
    f[75]    = c;
    f[74:72] = t;
    f[15:0]  = p;
    return f;
  endfunction

  function automatic vec_t mk(input logic v, input logic [LW-1:0] link, input logic [PW-1:0] pkt,
                              input logic ryumi, input logic rv, input logic [RW-1:0] rdata,
                              input logic yumi, input logic e_rdy, input logic e_rrdy,
                              input logic e_ringv, input logic [RW-1:0] e_rdata, input logic e_vo,
                              input logic [LW-1:0] e_link, input logic [PW-1:0] e_pkt,
                              input logic [NL*CW-1:0] e_cred, input logic [7:0] e_drop);
    vec_t r;
    r.v = v; r.link = link; r.pkt = pkt; r.ryumi = ryumi; r.rv = rv; r.rdata = rdata;
    r.yumi = yumi; r.e_rdy = e_rdy; r.e_rrdy = e_rrdy; r.e_ringv = e_ringv;
    r.e_rdata = e_rdata; r.e_vo = e_vo; r.e_link = e_link; r.e_pkt = e_pkt;
    r.e_cred = e_cred; r.e_drop = e_drop;
    return r;
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    v_i = 1'b0; link_i = '0; packet_i = '0; ring_yumi_i = 1'b0;
    ring_v_i = 1'b0; ring_data_i = '0; yumi_i = 1'b0;
  endtask

  initial begin
    // credits_o packs {link2, link1, link0}; 0x124 = all three at 4.
    vq.push_back(mk(1,1,16'h0101,1,0,'0,0, 1,1,1,fr(4'hA,0,2,16'h0101),0,0,0, 9'h11C,0));
    vq.push_back(mk(1,1,16'h0102,1,0,'0,0, 1,1,1,fr(4'hA,0,2,16'h0102),0,0,0, 9'h114,0));
    vq.push_back(mk(1,1,16'h0103,1,0,'0,0, 1,1,1,fr(4'hA,0,2,16'h0103),0,0,0, 9'h10C,0));
    vq.push_back(mk(1,1,16'h0104,1,0,'0,0, 1,1,1,fr(4'hA,0,2,16'h0104),0,0,0, 9'h104,0));
    vq.push_back(mk(1,1,16'h0105,1,0,'0,0, 0,1,0,'0,0,0,0, 9'h104,0));
    vq.push_back(mk(1,1,16'h0106,1,0,'0,0, 0,1,0,'0,0,0,0, 9'h104,0));
    vq.push_back(mk(0,0,16'h0000,1,0,'0,0, 1,1,0,'0,0,0,0, 9'h104,0));
    vq.push_back(mk(0,1,16'h0000,1,1,fr(4'hA,0,2,0),0, 0,1,0,'0,0,0,0, 9'h10C,0));
    vq.push_back(mk(0,1,16'h0000,1,0,'0,0, 1,1,0,'0,0,0,0, 9'h10C,0));
    // return path and FIFO full backpressure
    vq.push_back(mk(0,0,0,1,1,fr(4'hA,0,3,16'h0055),0, 1,1,0,'0,1,1,16'h0055, 9'h10C,0));
    vq.push_back(mk(0,0,0,1,1,fr(4'hA,0,1,16'h0066),0, 1,1,0,'0,1,1,16'h0055, 9'h10C,0));
    vq.push_back(mk(0,0,0,1,1,fr(4'hA,0,1,16'h0077),0, 1,0,0,'0,1,1,16'h0055, 9'h10C,0));
    vq.push_back(mk(0,0,0,1,0,'0,1, 1,0,0,'0,1,0,16'h0066, 9'h10C,0));
    vq.push_back(mk(0,0,0,1,0,'0,0, 1,1,0,'0,1,0,16'h0066, 9'h10C,0));
    vq.push_back(mk(0,0,0,1,0,'0,1, 1,1,0,'0,0,0,0, 9'h10C,0));
    // simultaneous accept and credit return on link 1 at count 2
    vq.push_back(mk(0,1,0,1,1,fr(4'hA,0,2,0),0, 1,1,0,'0,0,0,0, 9'h114,0));
    vq.push_back(mk(1,1,16'h0ABC,1,1,fr(4'hA,0,2,0),0, 1,1,1,fr(4'hA,0,2,16'h0ABC),0,0,0, 9'h114,0));
    vq.push_back(mk(0,1,0,1,0,'0,0, 1,1,0,'0,0,0,0, 9'h114,0));
    // discarded frames: wrong destid, cmd=1, tag out of range, credit at max
    vq.push_back(mk(0,0,0,0,1,fr(4'h5,0,0,0),0, 1,1,0,'0,0,0,0, 9'h114,1));
    vq.push_back(mk(0,0,0,0,1,fr(4'hA,1,1,16'h0011),0, 1,1,0,'0,0,0,0, 9'h114,2));
    vq.push_back(mk(0,0,0,0,1,fr(4'hA,0,7,0),0, 1,1,0,'0,0,0,0, 9'h114,3));
    vq.push_back(mk(0,0,0,0,1,fr(4'hA,0,4,0),0, 1,1,0,'0,0,0,0, 9'h114,4));
    // encoding, then ring backpressure holding the frame
    vq.push_back(mk(1,0,16'h1234,0,0,'0,0, 1,1,1,fr(4'hA,0,0,16'h1234),0,0,0, 9'h113,4));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(1,0,16'h9999,0,0,'0,0, 0,1,1,fr(4'hA,0,0,16'h1234),0,0,0, 9'h113,4));

    drive_idle();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ring_v", 80'(ring_v_o), 80'(1'b0));
    chk("reset_v_o", 80'(v_o), 80'(1'b0));
    chk("reset_credits", 80'(credits_o), 80'(9'h124));
    chk("reset_drop", 80'(drop_count_o), 80'(8'd0));
    reset_i = 1'b0;
    for (int l = 0; l < NL; l++) begin
      link_i = LW'(l);
      #1;
      chk("reset_ready", 80'(ready_o), 80'(1'b1));
    end
    chk("reset_ring_ready", 80'(ring_ready_o), 80'(1'b1));
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      v_i = vq[i].v; link_i = vq[i].link; packet_i = vq[i].pkt;
      ring_yumi_i = vq[i].ryumi; ring_v_i = vq[i].rv; ring_data_i = vq[i].rdata;
      yumi_i = vq[i].yumi;
      #1;
      chk($sformatf("v%0d_ready", i), 80'(ready_o), 80'(vq[i].e_rdy));
      chk($sformatf("v%0d_ring_ready", i), 80'(ring_ready_o), 80'(vq[i].e_rrdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ring_v", i), 80'(ring_v_o), 80'(vq[i].e_ringv));
      if (vq[i].e_ringv) chk($sformatf("v%0d_ring_data", i), ring_data_o, vq[i].e_rdata);
      chk($sformatf("v%0d_v_o", i), 80'(v_o), 80'(vq[i].e_vo));
      if (vq[i].e_vo) begin
        chk($sformatf("v%0d_link_o", i), 80'(link_o), 80'(vq[i].e_link));
        chk($sformatf("v%0d_packet_o", i), 80'(packet_o), 80'(vq[i].e_pkt));
      end
      chk($sformatf("v%0d_credits", i), 80'(credits_o), 80'(vq[i].e_cred));
      chk($sformatf("v%0d_drop", i), 80'(drop_count_o), 80'(vq[i].e_drop));
    end

    // Field-level view of the held frame
    chk("enc_destid", 80'(ring_data_o[79:76]), 80'(4'hA));
    chk("enc_cmd", 80'(ring_data_o[75]), 80'(1'b0));
    chk("enc_tag", 80'(ring_data_o[74:72]), 80'(3'd0));
    chk("enc_payload", 80'(ring_data_o[15:0]), 80'(16'h1234));

    // Queue a return while the frame is stuck, then reset mid-operation
    ring_v_i = 1'b1;
    ring_data_i = fr(4'hA, 0, 5, 16'h00AA);
    @(posedge clk);
    #1;
    ring_v_i = 1'b0;
    chk("pre_reset_v_o", 80'(v_o), 80'(1'b1));
    chk("pre_reset_link_o", 80'(link_o), 80'(2'd2));
    chk("pre_reset_ring_v", 80'(ring_v_o), 80'(1'b1));
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    v_i = 1'b0;
    chk("mid_reset_ring_v", 80'(ring_v_o), 80'(1'b0));
    chk("mid_reset_v_o", 80'(v_o), 80'(1'b0));
    chk("mid_reset_credits", 80'(credits_o), 80'(9'h124));
    chk("mid_reset_drop", 80'(drop_count_o), 80'(8'd0));
    link_i = 2'd0;
    #1;
    chk("mid_reset_ready", 80'(ready_o), 80'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
